// File: rtl/qdiv_arb.sv
// qdiv_arb: four-requester front end for one shared sign-magnitude
// fixed-point divider (Q fractional bits, N-bit words, bit N-1 = sign).
// Ports: clk, rst (sync, active-high); req/req_dividend/req_divisor in,
// gnt out (one-hot pulse, operands captured that cycle); rsp_valid,
// rsp_id, rsp_quotient, rsp_dz, busy out; div_dividend, div_divisor,
// div_start to the divider; div_quotient, div_complete from it.
// Define QDIV_ARB_RR_EN for round-robin arbitration; the default build
// uses fixed priority (lowest index wins).
module qdiv_arb #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] req_dividend,
  input  logic [4*N-1:0] req_divisor,
  output logic [3:0]     gnt,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [N-1:0]   rsp_quotient,
  output logic           rsp_dz,
  output logic           busy,
  output logic [N-1:0]   div_dividend,
  output logic [N-1:0]   div_divisor,
  output logic           div_start,
  input  logic [N-1:0]   div_quotient,
  input  logic           div_complete
);

  // Q only matters to the divider; it must leave room for the sign bit.
  if (Q < 0 || Q > N - 2) begin : g_bad_q
    $error("qdiv_arb: Q out of range for N");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cap_dd_q, cap_dd_d;
  logic [N-1:0] cap_dv_q, cap_dv_d;
  logic [1:0]   cap_id_q, cap_id_d;
  logic [N-1:0] rsp_q_q, rsp_q_d;
  logic [1:0]   rsp_id_q, rsp_id_d;
  logic         rsp_dz_q, rsp_dz_d;

  logic         any_req;
  logic [1:0]   win_idx;
  logic [N-1:0] win_dd;
  logic [N-1:0] win_dv;
  logic         win_dz;

  assign any_req = |req;

`ifdef QDIV_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Search starts one past the last winner; k=4 wraps back onto it.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    idx     = 2'd0;
    win_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win_idx = idx;
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win_idx = 2'(k);
    end
  end
`endif

  assign win_dd = req_dividend[win_idx*N +: N];
  assign win_dv = req_divisor[win_idx*N +: N];
  assign win_dz = (win_dv[N-2:0] == '0);

  always_comb begin
    state_d  = state_q;
    cap_dd_d = cap_dd_q;
    cap_dv_d = cap_dv_q;
    cap_id_d = cap_id_q;
    rsp_q_d  = rsp_q_q;
    rsp_id_d = rsp_id_q;
    rsp_dz_d = rsp_dz_q;
`ifdef QDIV_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          cap_dd_d = win_dd;
          cap_dv_d = win_dv;
          cap_id_d = win_idx;
`ifdef QDIV_ARB_RR_EN
          ptr_d    = win_idx;
`endif
          if (win_dz) begin
            // Saturated magnitude with the product sign.
            rsp_q_d  = {win_dd[N-1] ^ win_dv[N-1],
                        {(N-1){1'b1}}};
            rsp_dz_d = 1'b1;
            rsp_id_d = win_idx;
            state_d  = RESP;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      // Divider may still be busy from before a reset.
      ISSUE: if (div_complete) state_d = ARM;
      ARM:   if (!div_complete) state_d = BUSY;
      BUSY: begin
        if (div_complete) begin
          rsp_q_d  = div_quotient;
          rsp_dz_d = 1'b0;
          rsp_id_d = cap_id_q;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cap_dd_q <= '0;
      cap_dv_q <= '0;
      cap_id_q <= '0;
      rsp_q_q  <= '0;
      rsp_id_q <= '0;
      rsp_dz_q <= 1'b0;
`ifdef QDIV_ARB_RR_EN
      ptr_q    <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      cap_dd_q <= cap_dd_d;
      cap_dv_q <= cap_dv_d;
      cap_id_q <= cap_id_d;
      rsp_q_q  <= rsp_q_d;
      rsp_id_q <= rsp_id_d;
      rsp_dz_q <= rsp_dz_d;
`ifdef QDIV_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Strobes are masked by rst so a reset cycle never grants or responds.
  assign gnt = (state_q == IDLE && any_req && !rst)
             ? (4'b0001 << win_idx) : 4'b0000;
  assign rsp_valid    = (state_q == RESP) && !rst;
  assign div_start    = (state_q == ISSUE) && !rst;
  assign busy         = (state_q != IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_quotient = rsp_q_q;
  assign rsp_dz       = rsp_dz_q;
  assign div_dividend = cap_dd_q;
  assign div_divisor  = cap_dv_q;

endmodule

// File: tb/tb_qdiv_arb.sv
// Directed bench for qdiv_arb with a behavioural shared divider.
// Build with +define+QDIV_ARB_RR_EN to check the round-robin order.
module tb_qdiv_arb;
  localparam int N   = 32;
  localparam int Q   = 15;
  localparam int LAT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] req_dividend;
  logic [4*N-1:0] req_divisor;
  logic [3:0]     gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_quotient;
  logic           rsp_dz;
  logic           busy;
  logic [N-1:0]   div_dividend;
  logic [N-1:0]   div_divisor;
  logic           div_start;
  logic [N-1:0]   div_quotient;
  logic           div_complete;

  always #5 clk = ~clk;

  qdiv_arb #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_dz(rsp_dz), .busy(busy),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_quotient(div_quotient),
    .div_complete(div_complete)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shared divider stand-in: never reset, so it keeps running across
  // a DUT reset.
  logic         dv_done = 1'b1;
  logic [N-1:0] dv_q    = '0;
  logic [N-1:0] m_dd    = '0;
  logic [N-1:0] m_dv    = '1;
  int           dv_cnt  = 0;

  function automatic logic [N-1:0] qdiv(input logic [N-1:0] a,
                                        input logic [N-1:0] b);
    logic [63:0] mag;
    mag = ({33'b0, a[N-2:0]} << Q) / {33'b0, b[N-2:0]};
    return {a[N-1] ^ b[N-1], mag[N-2:0]};
  endfunction

  always @(posedge clk) begin
    if (div_start && dv_done) begin
      m_dd    <= div_dividend;
      m_dv    <= div_divisor;
      dv_cnt  <= LAT;
      dv_done <= 1'b0;
    end else if (!dv_done) begin
      if (dv_cnt == 1) begin
        dv_done <= 1'b1;
        dv_q    <= qdiv(m_dd, m_dv);
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  assign div_complete = dv_done;
  assign div_quotient = dv_q;

  int n_gnt   = 0;
  int n_rsp   = 0;
  int n_start = 0;
  always @(negedge clk) begin
    if (|gnt)      n_gnt   <= n_gnt + 1;
    if (rsp_valid) n_rsp   <= n_rsp + 1;
    if (div_start) n_start <= n_start + 1;
  end

  // Checks gnt now, then on each following negedge.
  task automatic wait_gnt(output logic [3:0] g, output int gc);
    bit found;
    found = 0;
    g     = '0;
    gc    = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      if (|gnt) begin
        g     = gnt;
        gc    = cyc;
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int rc);
    bit found;
    found = 0;
    rc    = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc    = cyc;
        found = 1;
      end
    end
    if (!found) chk("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [N-1:0] dd,
                         input logic [N-1:0] dv);
    req_dividend[idx*N +: N] = dd;
    req_divisor[idx*N +: N]  = dv;
  endtask

  task automatic run_op(input int idx, input logic [N-1:0] dd,
                        input logic [N-1:0] dv,
                        input logic [N-1:0] exp_q,
                        input logic exp_dz, input string tag);
    logic [3:0] g;
    int gc, rc, s0;
    @(negedge clk);
    s0 = n_start;
    set_ops(idx, dd, dv);
    req[idx] = 1'b1;
    #1;
    wait_gnt(g, gc);
    chk({tag, "_gnt"}, g, 64'(4'b0001 << idx));
    @(posedge clk);
    #1 req[idx] = 1'b0;
    wait_rsp(rc);
    chk({tag, "_id"}, rsp_id, idx);
    chk({tag, "_q"}, rsp_quotient, exp_q);
    chk({tag, "_dz"}, rsp_dz, exp_dz);
    if (exp_dz) chk({tag, "_lat"}, rc - gc, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, rsp_valid, 0);
    chk({tag, "_starts"}, n_start - s0, exp_dz ? 0 : 1);
  endtask

  logic [3:0] g;
  int gc, rc, g0, r0;
  int exp_i;

  initial begin
    rst          = 1'b1;
    req          = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {gnt, rsp_valid, busy, div_start, rsp_dz}, 0);
    chk("rst_q", rsp_quotient, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cap", {div_dividend, div_divisor}, 0);
    req = 4'hF;
    #1;
    chk("rst_no_gnt", gnt, 0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;

    run_op(0, 32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, "basic");
    run_op(1, 32'h80018000, 32'h00010000, 32'h8000C000, 1'b0, "sign");
    run_op(3, 32'h00018000, 32'h80000000, 32'hFFFFFFFF, 1'b1, "dz");
    repeat (3) @(negedge clk);
    chk("hold_q", rsp_quotient, 32'hFFFFFFFF);
    chk("hold_id", rsp_id, 3);
    run_op(2, 32'h00018000, 32'h00000000, 32'h7FFFFFFF, 1'b1, "dz_pos");
    run_op(1, 32'h00000001, 32'h00000001, 32'h00008000, 1'b0, "tiny");

    // Contention: all four held continuously.
    do_reset();
    for (int i = 0; i < 4; i++)
      set_ops(i, 32'((i + 1) * 32'h8000), 32'h00010000);
    g0  = n_gnt;
    r0  = n_rsp;
    req = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
`ifdef QDIV_ARB_RR_EN
      exp_i = k % 4;
`else
      exp_i = 0;
`endif
      wait_gnt(g, gc);
      chk($sformatf("cont_gnt%0d", k), g, 64'(4'b0001 << exp_i));
      wait_rsp(rc);
      chk($sformatf("cont_id%0d", k), rsp_id, exp_i);
      chk($sformatf("cont_q%0d", k), rsp_quotient,
          64'((exp_i + 1) * 32'h4000));
      if (k == 4) req = '0;
    end
    repeat (3) @(negedge clk);
    chk("cont_ngnt", n_gnt - g0, 5);
    chk("cont_nrsp", n_rsp - r0, 5);

    // Back-to-back: second grant right after the first response.
    do_reset();
    set_ops(0, 32'h00018000, 32'h00010000);
    set_ops(1, 32'h00040000, 32'h00010000);
    req = 4'b0011;
    #1;
    wait_gnt(g, gc);
    chk("b2b_gnt0", g, 4'b0001);
    @(posedge clk);
    #1 req[0] = 1'b0;
    wait_rsp(rc);
    chk("b2b_id0", rsp_id, 0);
    @(negedge clk);
    chk("b2b_gnt1", gnt, 4'b0010);
    @(posedge clk);
    #1 req[1] = 1'b0;
    wait_rsp(rc);
    chk("b2b_id1", rsp_id, 1);
    chk("b2b_q1", rsp_quotient, 32'h00020000);

    // Reset while BUSY, divider left running.
    @(negedge clk);
    set_ops(0, 32'h00018000, 32'h00010000);
    req[0] = 1'b1;
    #1;
    wait_gnt(g, gc);
    @(posedge clk);
    #1 req = '0;
    r0 = n_rsp;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q", rsp_quotient, 0);
    chk("mid_rst_cap", div_dividend, 0);
    rst = 1'b0;
    set_ops(2, 32'h00030000, 32'h00018000);
    req[2] = 1'b1;
    #1;
    wait_gnt(g, gc);
    chk("mid_gnt", g, 4'b0100);
    @(posedge clk);
    #1 req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_issue%0d", i), {busy, div_start}, 2'b11);
    end
    wait_rsp(rc);
    chk("mid_id", rsp_id, 2);
    chk("mid_q", rsp_quotient, 32'h00010000);
    chk("mid_dz", rsp_dz, 0);
    repeat (2) @(negedge clk);
    chk("mid_nrsp", n_rsp - r0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
